// File: rtl/cs_loop_sequencer.sv
// Current-source regulation loop sequencer: measure RO pulse rate, average, step thermometer code.
// Latency: COUNT_DONE one cycle after DECIDE, i.e. WINDOW_LEN*2^AVG_LOG2+1 cycles after MEASURE entry.
// Backpressure: none; RO_PULSE is sampled every MEASURE cycle, LOOP_BYPASS preempts any state.
//
// Ports:
//   CLK, RST_N                       clock, async active-low reset
//   ENABLE, LOOP_BYPASS              run request, forced-code override
//   NO_CURRENT_SOURCE[31:0]          code applied while bypassed
//   RO_PULSE                         synchronized divided-RO pulse
//   LOWER/UPPER_VOLTAGE_BOUND[7:0]   regulation band, sampled in DECIDE only
//   OUT_COUNT[31:0]                  thermometer current-source enables
//   AVG_COUNT[7:0], COUNT_DONE       last average and its update strobe
//   LOCKED, SAT_HI, SAT_LO, BUSY     loop status
module cs_loop_sequencer #(
    parameter int WINDOW_LEN    = 256,
    parameter int AVG_LOG2      = 2,
    parameter int SETTLE_CYCLES = 64,
    parameter int LOCK_WINDOWS  = 4
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        ENABLE,
    input  logic        LOOP_BYPASS,
    input  logic [31:0] NO_CURRENT_SOURCE,
    input  logic        RO_PULSE,
    input  logic [7:0]  LOWER_VOLTAGE_BOUND,
    input  logic [7:0]  UPPER_VOLTAGE_BOUND,
    output logic [31:0] OUT_COUNT,
    output logic [7:0]  AVG_COUNT,
    output logic        COUNT_DONE,
    output logic        LOCKED,
    output logic        SAT_HI,
    output logic        SAT_LO,
    output logic        BUSY
);

    localparam int WIN_W  = $clog2(WINDOW_LEN);
    localparam int NWIN   = 1 << AVG_LOG2;
    localparam int WIDX_W = AVG_LOG2 + 1;
    localparam int SET_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int ACC_W  = 8 + AVG_LOG2;

    localparam logic [WIN_W-1:0]  WIN_LAST    = WIN_W'(WINDOW_LEN - 1);
    localparam logic [WIDX_W-1:0] WIDX_LAST   = WIDX_W'(NWIN - 1);
    localparam logic [SET_W-1:0]  SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);
    localparam logic [3:0]        LOCK_MAX    = 4'(LOCK_WINDOWS);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        DECIDE  = 2'd2,
        SETTLE  = 2'd3
    } state_t;

    state_t            state, state_nxt;
    logic [WIN_W-1:0]  win_cnt;
    logic [WIDX_W-1:0] widx_cnt;
    logic [7:0]        pulse_cnt;
    logic [ACC_W-1:0]  acc;
    logic [SET_W-1:0]  settle_cnt;
    logic [3:0]        inband_cnt;

    logic       win_last, widx_last, settle_last;
    logic [7:0] pulse_nxt;
    logic [7:0] avg_now;
    logic       step_up, step_dn;

    always_comb begin
        win_last    = (win_cnt == WIN_LAST);
        widx_last   = (widx_cnt == WIDX_LAST);
        settle_last = (settle_cnt == SETTLE_LAST);
        // Saturating count including this cycle's pulse, so a pulse in the
        // window's last cycle still lands in that window's sum.
        pulse_nxt   = pulse_cnt;
        if (RO_PULSE && (pulse_cnt != 8'hFF)) begin
            pulse_nxt = pulse_cnt + 8'd1;
        end
        avg_now = acc[AVG_LOG2 +: 8];
        // Lower bound wins, so inverted bounds resolve to a step up.
        step_up = (avg_now < LOWER_VOLTAGE_BOUND);
        step_dn = !step_up && (avg_now > UPPER_VOLTAGE_BOUND);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (ENABLE) state_nxt = MEASURE;
            MEASURE: if (win_last && widx_last) state_nxt = DECIDE;
            DECIDE:  state_nxt = SETTLE;
            SETTLE:  if (settle_last) state_nxt = ENABLE ? MEASURE : IDLE;
            default: state_nxt = IDLE;
        endcase
        if (LOOP_BYPASS) begin
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            OUT_COUNT  <= 32'h0000_FFFF;
            AVG_COUNT  <= 8'd0;
            COUNT_DONE <= 1'b0;
            SAT_HI     <= 1'b0;
            SAT_LO     <= 1'b0;
            win_cnt    <= '0;
            widx_cnt   <= '0;
            pulse_cnt  <= '0;
            acc        <= '0;
            settle_cnt <= '0;
            inband_cnt <= '0;
        end else if (LOOP_BYPASS) begin
            OUT_COUNT  <= NO_CURRENT_SOURCE;
            COUNT_DONE <= 1'b0;
            win_cnt    <= '0;
            widx_cnt   <= '0;
            pulse_cnt  <= '0;
            acc        <= '0;
            settle_cnt <= '0;
            inband_cnt <= '0;
        end else begin
            COUNT_DONE <= 1'b0;
            case (state)
                IDLE: begin
                    win_cnt    <= '0;
                    widx_cnt   <= '0;
                    pulse_cnt  <= '0;
                    acc        <= '0;
                    settle_cnt <= '0;
                end
                MEASURE: begin
                    if (win_last) begin
                        acc       <= acc + ACC_W'(pulse_nxt);
                        pulse_cnt <= '0;
                        win_cnt   <= '0;
                        widx_cnt  <= widx_last ? '0 : widx_cnt + WIDX_W'(1);
                    end else begin
                        pulse_cnt <= pulse_nxt;
                        win_cnt   <= win_cnt + WIN_W'(1);
                    end
                end
                DECIDE: begin
                    AVG_COUNT  <= avg_now;
                    COUNT_DONE <= 1'b1;
                    acc        <= '0;
                    settle_cnt <= '0;
                    if (step_up) begin
                        SAT_LO     <= 1'b0;
                        inband_cnt <= '0;
                        SAT_HI     <= &OUT_COUNT;
                        if (!(&OUT_COUNT)) begin
                            OUT_COUNT <= {OUT_COUNT[30:0], 1'b1};
                        end
                    end else if (step_dn) begin
                        SAT_HI     <= 1'b0;
                        inband_cnt <= '0;
                        SAT_LO     <= (OUT_COUNT == 32'd0);
                        if (OUT_COUNT != 32'd0) begin
                            OUT_COUNT <= {1'b0, OUT_COUNT[31:1]};
                        end
                    end else begin
                        SAT_HI <= 1'b0;
                        SAT_LO <= 1'b0;
                        if (inband_cnt != LOCK_MAX) begin
                            inband_cnt <= inband_cnt + 4'd1;
                        end
                    end
                end
                SETTLE: begin
                    settle_cnt <= settle_last ? '0 : settle_cnt + SET_W'(1);
                end
                default: begin
                    settle_cnt <= '0;
                end
            endcase
        end
    end

    assign LOCKED = (inband_cnt == LOCK_MAX);
    assign BUSY   = (state != IDLE);

endmodule
